// File: rtl/mux8_rr_arbiter_pkg.sv
// mux8_arb_pkg: shared types, constants and round-robin search for mux8_rr_arbiter
// Contents: state_t (IDLE, FULL, LOCKED), N = 8 requesters, SELW = 3 select bits,
// rr_next(req, ptr) -> {hit, index} of the first high req after ptr, with wrap.
package mux8_arb_pkg;
    localparam int N = 8;
    localparam int SELW = 3;
    typedef enum logic [1:0] {IDLE, FULL, LOCKED} state_t;
    // Walk offsets 8 down to 1, so the smallest offset from ptr+1 is assigned last and wins.
    function automatic logic [SELW:0] rr_next(input logic [N-1:0] req, input logic [SELW-1:0] ptr);
        logic [SELW:0] r;
        logic [SELW-1:0] k;
        r = '0;
        for (int i = N; i >= 1; i--) begin
            k = ptr + SELW'(i);
            if (req[k]) r = {1'b1, k};
        end
        return r;
    endfunction
endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// mux8_arb_if: requester/consumer bundle of mux8_rr_arbiter (macro MUX_ARB_LOCK_EN adds lock)
// Signals: req, lock, in_data (sources -> arbiter); gnt, sel (arbiter -> sources);
// out_valid, out_data, out_src (arbiter -> consumer); out_ready (consumer -> arbiter).
// Modports: slave = arbiter side, master = sources/consumer side.
interface mux8_arb_if import mux8_arb_pkg::*; #(parameter int DW = 16);
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [N*DW-1:0] in_data;
    logic [SELW-1:0] sel;
    logic out_valid;
    logic out_ready;
    logic [DW-1:0] out_data;
    logic [SELW-1:0] out_src;
`ifdef MUX_ARB_LOCK_EN
    logic [N-1:0] lock;
    modport slave (input req, lock, in_data, out_ready, output gnt, sel, out_valid, out_data, out_src);
    modport master (output req, lock, in_data, out_ready, input gnt, sel, out_valid, out_data, out_src);
`else
    modport slave (input req, in_data, out_ready, output gnt, sel, out_valid, out_data, out_src);
    modport master (output req, in_data, out_ready, input gnt, sel, out_valid, out_data, out_src);
`endif
endinterface

// File: rtl/mux8_rr_arbiter_arb_mux8.sv
// arb_mux8: combinational 8:1 DW-bit lane select
// Ports: in_data (8 packed lanes, lane i at [i*DW +: DW]), sel (lane index), y (selected lane).
module arb_mux8 import mux8_arb_pkg::*; #(parameter int DW = 16) (
    input  logic [N*DW-1:0]  in_data,
    input  logic [SELW-1:0]  sel,
    output logic [DW-1:0]    y
);
    assign y = in_data[sel*DW +: DW];
endmodule

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin arbiter sharing one 8:1 mux, with a registered valid/ready output
// Ports: clk, rst (sync, active-high), bus (mux8_arb_if.slave: req/lock/in_data in,
// gnt/sel out, out_valid/out_data/out_src/out_ready towards the consumer).
// Macro MUX_ARB_LOCK_EN enables lock[] and the LOCKED state.
module mux8_rr_arbiter import mux8_arb_pkg::*; #(parameter int DW = 16) (
    input logic clk,
    input logic rst,
    mux8_arb_if.slave bus
);
    state_t state, state_n;
    logic [SELW-1:0] ptr, win, src_q;
    logic [SELW:0] pick;
    logic [N-1:0] elig;
    logic [DW-1:0] lane, data_q;
    logic load_en, xfer, lk, locked, valid_q;
`ifdef MUX_ARB_LOCK_EN
    logic [SELW-1:0] owner;
    // While locked only the owner may compete; everyone else stalls.
    assign locked = state == LOCKED;
    assign elig = locked ? (bus.req & (N'(1) << owner)) : bus.req;
    assign lk = bus.lock[win];
    always_ff @(posedge clk)
        if (rst) owner <= '0;
        else if (xfer && lk) owner <= win;
`else
    assign locked = 1'b0;
    assign elig = bus.req;
    assign lk = 1'b0;
`endif
    assign load_en = !valid_q | bus.out_ready;
    assign pick = rr_next(elig, ptr);
    assign win = pick[SELW-1:0];
    assign xfer = pick[SELW] & load_en & !rst;
    assign bus.gnt = xfer ? N'(1) << win : '0;
    assign bus.sel = xfer ? win : '0;
    assign bus.out_valid = valid_q;
    assign bus.out_data = data_q;
    assign bus.out_src = src_q;
    arb_mux8 #(.DW(DW)) u_mux (.in_data(bus.in_data), .sel(bus.sel), .y(lane));
    always_comb begin
        state_n = state;
        if (xfer) state_n = lk ? LOCKED : FULL;
        else if (state == FULL && bus.out_ready) state_n = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr <= SELW'(N-1);
            valid_q <= 1'b0;
            data_q <= '0;
            src_q <= '0;
        end else begin
            state <= state_n;
            if (xfer) begin
                valid_q <= 1'b1;
                data_q <= lane;
                src_q <= win;
            end else if (bus.out_ready) valid_q <= 1'b0;
            // Beats that keep the lock leave ptr alone; the releasing beat sets ptr = owner.
            if (xfer && !(locked && lk)) ptr <= win;
        end
    end
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: directed self-checking bench with a beat scoreboard (MUX_ARB_LOCK_EN adds lock steps)
module tb_mux8_rr_arbiter;
    import mux8_arb_pkg::*;
    typedef struct packed {logic [2:0] src; logic [15:0] data;} beat_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    mux8_arb_if #(.DW(16)) bus();
    mux8_rr_arbiter #(.DW(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    beat_t sb[$];
    int ncmp = 0;
    int nbad = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic logic [2:0] oh2i(input logic [7:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction
    task automatic set_lanes(input logic [15:0] base);
        for (int i = 0; i < 8; i++) bus.in_data[i*16 +: 16] = base | 16'(i);
    endtask
    // One clock: drive req/out_ready, check the combinational grant, then check the captured beat.
    task automatic cyc(input logic [7:0] r, input logic rdy, input logic [7:0] eg);
        beat_t b;
        logic [15:0] hold;
        bus.req = r;
        bus.out_ready = rdy;
        hold = bus.out_data;
        #1;
        chk("gnt", 32'(bus.gnt), 32'(eg));
        chk("sel", 32'(bus.sel), 32'(eg != 0 ? oh2i(eg) : 3'd0));
        if (eg != 0) sb.push_back({oh2i(eg), bus.in_data[oh2i(eg)*16 +: 16]});
        @(posedge clk);
        #1;
        if (eg != 0) begin
            b = sb.pop_front();
            chk("out_valid", 32'(bus.out_valid), 32'd1);
            chk("out_src", 32'(bus.out_src), 32'(b.src));
            chk("out_data", 32'(bus.out_data), 32'(b.data));
        end else if (rdy) chk("drain_valid", 32'(bus.out_valid), 32'd0);
        else chk("stall_data", 32'(bus.out_data), 32'(hold));
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end
    initial begin
        bus.req = '0;
        bus.out_ready = 1'b0;
        bus.in_data = '0;
`ifdef MUX_ARB_LOCK_EN
        bus.lock = '0;
`endif
        bus.req = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_sel", 32'(bus.sel), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_src", 32'(bus.out_src), 32'd0);
        rst = 1'b0;
        bus.in_data[15:0] = 16'h0001;
        cyc(8'h01, 1'b1, 8'h01);
        cyc(8'h00, 1'b1, 8'h00);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_lanes(16'h0000);
        for (int i = 0; i < 9; i++) cyc(8'hFF, 1'b1, 8'(1) << (i % 8));
        cyc(8'h00, 1'b1, 8'h00);
        set_lanes(16'hC000);
        cyc(8'h01, 1'b1, 8'h01);
        repeat (3) cyc(8'h0C, 1'b0, 8'h00);
        cyc(8'h0C, 1'b1, 8'h04);
        cyc(8'h08, 1'b1, 8'h08);
        cyc(8'h00, 1'b1, 8'h00);
        cyc(8'h01, 1'b1, 8'h01);
        cyc(8'h81, 1'b1, 8'h80);
        cyc(8'h81, 1'b1, 8'h01);
        cyc(8'h00, 1'b1, 8'h00);
        cyc(8'hFF, 1'b1, 8'h02);
        rst = 1'b1;
        #1;
        chk("midrst_gnt", 32'(bus.gnt), 32'd0);
        chk("midrst_sel", 32'(bus.sel), 32'd0);
        @(posedge clk);
        #1;
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b0;
        cyc(8'h06, 1'b1, 8'h02);
`ifdef MUX_ARB_LOCK_EN
        cyc(8'h10, 1'b1, 8'h10);
        bus.lock = 8'h20;
        cyc(8'hFF, 1'b1, 8'h20);
        cyc(8'hFF, 1'b1, 8'h20);
        bus.lock = 8'h00;
        cyc(8'hFF, 1'b1, 8'h20);
        cyc(8'hFF, 1'b1, 8'h40);
        cyc(8'h00, 1'b1, 8'h00);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and output stage that shares one 16-bit 8:1 multiplexer among eight requesters. It picks one requester per cycle, drives the 3-bit mux select, and captures the selected lane into a registered valid/ready output. It sits between eight independent data sources and a single downstream consumer.

## Interface
Parameters:
- DW, 16, data width per lane.
- N, 8, requester count; fixed at 8, which fixes the select width at 3 bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset: synchronous, active-high.
- req  in  8  request from requester i; the requester holds it high until granted.
- lock  in  8  present only with MUX_ARB_LOCK_EN; sampled with the granted beat.
- in_data  in  8*DW  lane i is in_data[i*DW +: DW]; held stable while req[i] is high.
- gnt  out  8  one-hot combinational accept; the transfer occurs at the edge where req[i] and gnt[i] are both high.
- sel  out  3  mux select = index of the current grant; 0 when gnt is 0.
- out_valid  out  1  output register holds a beat.
- out_data  out  DW  captured lane data.
- out_src  out  3  index of the requester that produced out_data.
- out_ready  in  1  consumer accepts; the beat drains when out_valid and out_ready are both high.

## Operation
- load_en = !out_valid | out_ready.
- gnt is nonzero only when load_en = 1 and at least one req is high.
- Arbitration:
  - Search from (ptr+1) mod 8 upward with wrap; the first high req wins.
  - On a transfer, ptr <= winner.
  - Reset sets ptr = 7, so requester 0 has first priority.
- Capture: on a transfer, out_data <= selected lane, out_src <= winner, out_valid <= 1.
- Drain without a new grant: out_valid <= 0. out_data and out_src keep their last values.
- FSM states are IDLE (register empty), FULL (beat held) and LOCKED (macro only).
  - IDLE -> FULL on a grant.
  - FULL -> FULL on drain plus grant, or on a stall.
  - FULL -> IDLE on drain with no grant.
- Reset values: out_valid=0, out_data=0, out_src=0, ptr=7, state IDLE. gnt=0 and sel=0 during reset.
- Boundaries:
  - All eight requesters active: each is granted exactly once per 8 transfers.
  - Stall (out_valid=1, out_ready=0): gnt=0, and out_data/out_src hold.
  - Req dropped before its grant: no transfer and no pointer change.
  - Reset asserted mid-stream: any held beat is discarded and out_valid=0 on the next cycle.
  - Only one req high: it is granted every cycle while load_en=1, giving full throughput.

## Timing
- Latency: a req accepted at edge k gives out_valid=1 with that data after edge k.
- Throughput: one beat per cycle while out_ready stays high.
- gnt and sel are combinational from req, ptr, state, out_valid and out_ready. There is no combinational path from in_data to any output except through the register.

## Configuration
- MUX_ARB_LOCK_EN defined:
  - The lock port and the LOCKED state exist.
  - A transfer with lock[winner]=1 enters LOCKED with owner=winner.
  - While LOCKED, only req[owner] can be granted; all other requesters stall.
  - A transfer from the owner with lock=0 returns the FSM to FULL.
  - ptr is not updated by locked beats until the releasing beat, which sets ptr=owner.
  - Reset clears the lock.
- MUX_ARB_LOCK_EN undefined: no lock port, no LOCKED state, pure round-robin.

## Structure
- Package mux8_arb_pkg holds:
  - the state enum (IDLE, FULL, LOCKED);
  - constants N=8 and SELW=3;
  - the round-robin next-index function.
- One sub-module, arb_mux8: purely combinational 8:1 DW-bit select driven by sel.

## Test plan
- Reset then req=8'h01 with lane0=16'h0001 and out_ready=1 -> gnt=8'h01, sel=0. The next cycle shows out_valid=1, out_data=16'h0001, out_src=0.
- req=8'hFF held with lane i = i and out_ready=1 -> out_src sequence 0,1,...,7,0, one beat per cycle.
- out_valid=1 with out_ready=0 for 3 cycles while req=8'h0C -> gnt=0 and out_data stable. After out_ready rises, requester 2 is granted, then requester 3.
- req=8'h81 and ptr=0 -> requester 7 wins, then requester 0.
- With MUX_ARB_LOCK_EN, requester 5 sends 3 beats with lock=1,1,0 while req=8'hFF -> out_src is 5,5,5, then 6.
- rst pulsed while out_valid=1 -> out_valid=0 and ptr=7. The next grant goes to the lowest active index.
